// File: rtl/axi_full_mem_slave.sv
// AXI4-full responder over a 64-bit word memory; independent read and write FSMs.
// Optional WRAP burst support is enabled by defining AXI_SLV_WRAP_EN.
module axi_full_mem_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          MEM_AW    = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    input  logic [1:0]  arburst,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    output logic        arready,
    output logic [63:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    output logic        rlast,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    input  logic [1:0]  awburst,
    input  logic [7:0]  awlen,
    output logic        awready,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int DEPTH = 2 ** MEM_AW;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    // Whole-burst legality, decided once at the address handshake.
    function automatic logic burst_err(input logic [31:0] addr, input logic [7:0] len,
                                       input logic [1:0] burst);
        logic [28:0] widx;
        logic [32:0] last;
        logic        err;
        widx = 29'((addr - BASE_ADDR) >> 3);
        err  = (addr[2:0] != 3'd0) || (addr < BASE_ADDR);
        last = {4'd0, widx};
        case (burst)
            BURST_FIXED: ;
            BURST_INCR:  last = {4'd0, widx} + {25'd0, len};
`ifdef AXI_SLV_WRAP_EN
            BURST_WRAP: begin
                if (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)
                    last = {4'd0, widx | {21'd0, len}};
                else
                    err = 1'b1;
            end
`endif
            default:     err = 1'b1;
        endcase
        return err || (last >= 33'(DEPTH));
    endfunction

    logic [63:0] mem [DEPTH];
    logic        live;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) live <= 1'b0;
        else      live <= 1'b1;
    end

    // ---------------- read channel ----------------
    r_state_t          r_state, r_next;
    logic [MEM_AW-1:0] r_idx, r_nidx, rd_idx, ar_idx;
    logic [7:0]        r_len, r_cnt;
    logic [1:0]        r_burst;
    logic              r_err, ar_err, ar_hs, r_hs;

    assign ar_idx = MEM_AW'((araddr - BASE_ADDR) >> 3);
    assign ar_err = burst_err(araddr, arlen, arburst) || (arsize != 3'd3);
    assign ar_hs  = arvalid && arready;
    assign r_hs   = rvalid && rready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= R_IDLE;
        else      r_state <= r_next;
    end

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = live;
                if (ar_hs) r_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (r_hs && rlast) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        r_nidx = r_idx + 1'b1;
        case (r_burst)
            BURST_FIXED: r_nidx = r_idx;
`ifdef AXI_SLV_WRAP_EN
            BURST_WRAP:  r_nidx = (r_idx & ~MEM_AW'(r_len)) | ((r_idx + 1'b1) & MEM_AW'(r_len));
`endif
            default: ;
        endcase
        rd_idx = (r_state == R_IDLE) ? ar_idx : r_nidx;
    end

    // Memory writes use NBAs too, so a load here sees only earlier-committed data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_burst <= '0;
            r_err   <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            rlast   <= 1'b0;
        end else if (ar_hs) begin
            r_idx   <= ar_idx;
            r_len   <= arlen;
            r_cnt   <= '0;
            r_burst <= arburst;
            r_err   <= ar_err;
            rdata   <= ar_err ? 64'd0 : mem[rd_idx];
            rresp   <= ar_err ? RESP_SLVERR : RESP_OKAY;
            rlast   <= (arlen == 8'd0);
        end else if (r_hs && !rlast) begin
            r_idx <= r_nidx;
            r_cnt <= r_cnt + 8'd1;
            rdata <= r_err ? 64'd0 : mem[rd_idx];
            rlast <= (r_cnt + 8'd1 == r_len);
        end
    end

    // ---------------- write channel ----------------
    w_state_t          w_state, w_next;
    logic [MEM_AW-1:0] w_idx, w_nidx;
    logic [7:0]        w_len, w_cnt;
    logic [1:0]        w_burst;
    logic              w_err, w_lerr, aw_hs, w_hs, w_final, w_mism;

    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign w_final = (w_cnt == w_len);
    assign w_mism  = (wlast != w_final);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) w_state <= W_IDLE;
        else      w_state <= w_next;
    end

    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = live;
                if (aw_hs) w_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (w_hs && w_final) w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        w_nidx = w_idx + 1'b1;
        case (w_burst)
            BURST_FIXED: w_nidx = w_idx;
`ifdef AXI_SLV_WRAP_EN
            BURST_WRAP:  w_nidx = (w_idx & ~MEM_AW'(w_len)) | ((w_idx + 1'b1) & MEM_AW'(w_len));
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_idx   <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
            w_lerr  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else if (aw_hs) begin
            w_idx   <= MEM_AW'((awaddr - BASE_ADDR) >> 3);
            w_len   <= awlen;
            w_cnt   <= '0;
            w_burst <= awburst;
            w_err   <= burst_err(awaddr, awlen, awburst);
            w_lerr  <= 1'b0;
        end else if (w_hs) begin
            w_idx <= w_nidx;
            w_cnt <= w_cnt + 8'd1;
            if (w_mism) w_lerr <= 1'b1;
            if (w_final)
                bresp <= (w_err || w_lerr || w_mism) ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // Errored bursts are drained but never touch the array.
    always_ff @(posedge clk) begin
        if (w_hs && !w_err) begin
            for (int b = 0; b < 8; b++)
                if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_axi_full_mem_slave.sv
// Scoreboard bench for axi_full_mem_slave: directed bursts, monitor compares R/B beats.
module tb_axi_full_mem_slave;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          AW   = 12;
    localparam logic [1:0]  FIX = 2'b00, INC = 2'b01, WRP = 2'b10;
    localparam logic [1:0]  OK = 2'b00, ERR = 2'b10;

    logic        clk, rst;
    logic [31:0] araddr, awaddr;
    logic        arvalid, arready, rvalid, rlast, rready;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic [7:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize;
    logic [63:0] rdata, wdata;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    axi_full_mem_slave #(.BASE_ADDR(BASE), .MEM_AW(AW)) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arburst(arburst), .arlen(arlen),
        .arsize(arsize), .arready(arready), .rdata(rdata), .rresp(rresp),
        .rvalid(rvalid), .rlast(rlast), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awburst(awburst), .awlen(awlen),
        .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid),
        .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    rbeat_t      rq[$];
    logic [1:0]  bq[$];
    logic [63:0] wb[16];
    int          checks = 0;
    int          fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        checks++;
        fails++;
        $display("FAIL %s: got unexpected condition, expected normal handshake", name);
    endtask

    // Monitor: R and B beats are compared against queued expectations at negedge.
    always @(negedge clk) begin
        if (rst) begin
            if (rvalid) begin
                if (rq.size() == 0) bad("r_unexpected");
                else begin
                    chk("rdata", rdata, rq[0].data);
                    chk("rresp", 64'(rresp), 64'(rq[0].resp));
                    chk("rlast", 64'(rlast), 64'(rq[0].last));
                    if (rready) void'(rq.pop_front());
                end
            end
            if (bvalid && bready) begin
                if (bq.size() == 0) bad("b_unexpected");
                else chk("bresp", 64'(bresp), 64'(bq.pop_front()));
            end
        end
    end

    task automatic exp_r(input logic [63:0] d, input logic [1:0] r, input logic l);
        rbeat_t e;
        e.data = d; e.resp = r; e.last = l;
        rq.push_back(e);
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && (rq.size() != 0 || bq.size() != 0); n++) @(posedge clk);
        if (rq.size() != 0 || bq.size() != 0) begin
            bad("drain_timeout");
            rq.delete();
            bq.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic ar_phase(input logic [31:0] a, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size);
        bit ok = 0;
        araddr = a; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (arready) ok = 1;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        if (!ok) bad("ar_timeout");
        else chk("rvalid_latency", 64'(rvalid), 64'd1);
    endtask

    task automatic aw_phase(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst);
        bit ok = 0;
        awaddr = a; awlen = len; awburst = burst; awvalid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (awready) ok = 1;
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
        if (!ok) bad("aw_timeout");
    endtask

    task automatic w_phase(input logic [7:0] len, input logic [7:0] strb, input int wl);
        for (int i = 0; i <= int'(len); i++) begin
            bit ok = 0;
            wvalid = 1'b1; wdata = wb[i]; wstrb = strb; wlast = (i == wl);
            for (int n = 0; n < 100 && !ok; n++) begin
                @(negedge clk);
                if (wready) ok = 1;
            end
            @(posedge clk); #1;
            if (!ok) bad("w_timeout");
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                      input logic [7:0] strb, input int wl, input logic [1:0] eb);
        bq.push_back(eb);
        aw_phase(a, len, burst);
        w_phase(len, strb, wl);
        drain();
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                      input logic [2:0] size);
        ar_phase(a, len, burst, size);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        araddr = '0; arvalid = 0; arburst = INC; arlen = 0; arsize = 3'd3; rready = 1'b1;
        awaddr = '0; awvalid = 0; awburst = INC; awlen = 0;
        wdata = '0; wstrb = '0; wlast = 0; wvalid = 0; bready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_rvalid",  64'(rvalid),  64'd0);
        chk("rst_wready",  64'(wready),  64'd0);
        chk("rst_bvalid",  64'(bvalid),  64'd0);
        chk("rst_rdata",   rdata,        64'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // full-word write and readback
        wb[0] = 64'h1122_3344_5566_7788;
        wr(BASE, 0, INC, 8'hFF, 0, OK);
        exp_r(64'h1122_3344_5566_7788, OK, 1'b1);
        rd(BASE, 0, INC, 3'd3);

        // low-half byte strobes
        wb[0] = 64'hAAAA_AAAA_BBBB_BBBB;
        wr(BASE, 0, INC, 8'h0F, 0, OK);
        exp_r(64'h1122_3344_BBBB_BBBB, OK, 1'b1);
        rd(BASE, 0, INC, 3'd3);

        // INCR len 1 with R backpressure on beat 0
        wb[0] = 64'hA; wb[1] = 64'hB;
        wr(BASE + 32'h10, 1, INC, 8'hFF, 1, OK);
        exp_r(64'hA, OK, 1'b0);
        exp_r(64'hB, OK, 1'b1);
        rready = 1'b0;
        ar_phase(BASE + 32'h10, 1, INC, 3'd3);
        repeat (3) @(posedge clk);
        #1 rready = 1'b1;
        drain();

        // below-base read, out-of-range write (aliases word 0 if not blocked)
        exp_r(64'd0, ERR, 1'b1);
        rd(32'h7FFF_FFF8, 0, INC, 3'd3);
        wb[0] = 64'hDEAD_BEEF_DEAD_BEEF;
        wr(BASE + 32'h8000, 0, INC, 8'hFF, 0, ERR);
        exp_r(64'h1122_3344_BBBB_BBBB, OK, 1'b1);
        rd(BASE, 0, INC, 3'd3);

        // misaligned read and bad arsize
        exp_r(64'd0, ERR, 1'b1);
        rd(BASE + 32'h4, 0, INC, 3'd3);
        exp_r(64'd0, ERR, 1'b1);
        rd(BASE, 0, INC, 3'd2);

        // read-data load coinciding with a write beat to the same word
        wb[0] = 64'h5;
        wr(BASE, 0, INC, 8'hFF, 0, OK);
        bq.push_back(OK);
        exp_r(64'h5, OK, 1'b1);
        aw_phase(BASE, 0, INC);
        wvalid = 1'b1; wdata = 64'h6; wstrb = 8'hFF; wlast = 1'b1;
        araddr = BASE; arlen = 0; arburst = INC; arsize = 3'd3; arvalid = 1'b1;
        @(negedge clk);
        chk("coincident_ready", 64'({arready, wready}), 64'd3);
        @(posedge clk); #1;
        arvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
        drain();
        exp_r(64'h6, OK, 1'b1);
        rd(BASE, 0, INC, 3'd3);

        // early wlast: error response but data still lands
        wb[0] = 64'h77; wb[1] = 64'h88;
        wr(BASE + 32'h20, 1, INC, 8'hFF, 0, ERR);
        exp_r(64'h77, OK, 1'b0);
        exp_r(64'h88, OK, 1'b1);
        rd(BASE + 32'h20, 1, INC, 3'd3);

        // FIXED bursts stay on one word
        wb[0] = 64'h1; wb[1] = 64'h2;
        wr(BASE + 32'h40, 1, FIX, 8'hFF, 1, OK);
        exp_r(64'h2, OK, 1'b0);
        exp_r(64'h2, OK, 1'b1);
        rd(BASE + 32'h40, 1, FIX, 3'd3);

        // WRAP len 3 starting at word 3
        wb[0] = 64'h100; wb[1] = 64'h101; wb[2] = 64'h102; wb[3] = 64'h103;
        wr(BASE, 3, INC, 8'hFF, 3, OK);
`ifdef AXI_SLV_WRAP_EN
        exp_r(64'h103, OK, 1'b0);
        exp_r(64'h100, OK, 1'b0);
        exp_r(64'h101, OK, 1'b0);
        exp_r(64'h102, OK, 1'b1);
`else
        exp_r(64'd0, ERR, 1'b0);
        exp_r(64'd0, ERR, 1'b0);
        exp_r(64'd0, ERR, 1'b0);
        exp_r(64'd0, ERR, 1'b1);
`endif
        rd(BASE + 32'h18, 3, WRP, 3'd3);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
